// File: rtl/ybus_arbiter.sv
// Round-robin arbiter sharing one 4-phase Y channel among N_REQ write buffers; winner locked for a full handshake.
// YREQ rises 1 cycle after a request is sampled; waiting requesters are held off until the channel returns to IDLE.
module ybus_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_yreq,
  input  logic [N_REQ*DW-1:0]          req_ydata,
  input  logic [N_REQ-1:0]             req_yparity,
  output logic [N_REQ-1:0]             req_yack,
  input  logic                         PARITYSEL,
  output logic                         YREQ,
  output logic [DW-1:0]                YDATA,
  output logic                         YPARITY,
  input  logic                         YACK,
  output logic [$clog2(N_REQ)-1:0]     GRANT_ID,
  output logic                         BUSY,
  output logic                         PERR
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, FWD, RELS} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     last, last_nxt;
  logic [GW-1:0]     gid_nxt;
  logic              yreq_nxt, ypar_nxt, perr_nxt, busy_nxt;
  logic [DW-1:0]     ydata_nxt;
  logic [N_REQ-1:0]  yack_nxt;

  logic              win_vld;
  logic [GW-1:0]     win_id;
  logic [DW-1:0]     win_data;
  logic              win_par_exp;

  // Descending scan so the requester closest after 'last' is assigned last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req_yreq[idx]) begin
        win_vld = 1'b1;
        win_id  = idx[GW-1:0];
      end
    end
  end

  assign win_data    = req_ydata[int'(win_id)*DW +: DW];
  assign win_par_exp = (^win_data) ^ PARITYSEL;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gid_nxt   = GRANT_ID;
    yreq_nxt  = YREQ;
    ydata_nxt = YDATA;
    ypar_nxt  = YPARITY;
    yack_nxt  = req_yack;
    perr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gid_nxt   = win_id;
          ydata_nxt = win_data;
          ypar_nxt  = req_yparity[win_id];
          perr_nxt  = req_yparity[win_id] != win_par_exp;
          yreq_nxt  = 1'b1;
          state_nxt = FWD;
        end
      end
      FWD: begin
        if (YACK) begin
          yreq_nxt  = 1'b0;
          yack_nxt  = {{(N_REQ-1){1'b0}}, 1'b1} << GRANT_ID;
          state_nxt = RELS;
        end
      end
      RELS: begin
        // A winner that dropped its request early leaves only YACK gating the exit.
        if (!req_yreq[GRANT_ID] && !YACK) begin
          yack_nxt  = '0;
          last_nxt  = GRANT_ID;
          state_nxt = IDLE;
        end
      end
      default: begin
        yreq_nxt  = 1'b0;
        yack_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = state_nxt != IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= GW'(N_REQ - 1);
      GRANT_ID <= '0;
      YREQ     <= 1'b0;
      YDATA    <= '0;
      YPARITY  <= 1'b0;
      req_yack <= '0;
      PERR     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      GRANT_ID <= gid_nxt;
      YREQ     <= yreq_nxt;
      YDATA    <= ydata_nxt;
      YPARITY  <= ypar_nxt;
      req_yack <= yack_nxt;
      PERR     <= perr_nxt;
      BUSY     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ybus_arbiter.sv
// Directed bench for ybus_arbiter: expected grants are queued as requests are raised and checked when YREQ rises.
module tb_ybus_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_yreq;
  logic [N*DW-1:0] req_ydata;
  logic [N-1:0]    req_yparity;
  logic [N-1:0]    req_yack;
  logic            PARITYSEL;
  logic            YREQ;
  logic [DW-1:0]   YDATA;
  logic            YPARITY;
  logic            YACK;
  logic [1:0]      GRANT_ID;
  logic            BUSY;
  logic            PERR;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [1:0]  gid;
    logic [31:0] data;
    logic        par;
    logic        perr;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  cur_gid;
  logic [31:0] cur_data;

  always #5 clk = ~clk;

  ybus_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_yreq(req_yreq), .req_ydata(req_ydata), .req_yparity(req_yparity),
    .req_yack(req_yack), .PARITYSEL(PARITYSEL),
    .YREQ(YREQ), .YDATA(YDATA), .YPARITY(YPARITY), .YACK(YACK),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .PERR(PERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_yreq"},     YREQ,     0);
    chk({tag, "_ydata"},    YDATA,    0);
    chk({tag, "_yparity"},  YPARITY,  0);
    chk({tag, "_grant_id"}, GRANT_ID, 0);
    chk({tag, "_busy"},     BUSY,     0);
    chk({tag, "_perr"},     PERR,     0);
    chk({tag, "_req_yack"}, req_yack, 0);
  endtask

  // Expected result of granting requester id with whatever it currently drives.
  task automatic expect_grant(input int id);
    exp_t e;
    e.gid  = 2'(id);
    e.data = req_ydata[id*DW +: DW];
    e.par  = req_yparity[id];
    e.perr = req_yparity[id] ^ (^e.data) ^ PARITYSEL;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int id, input logic [31:0] d, input logic p);
    req_ydata[id*DW +: DW] = d;
    req_yparity[id]        = p;
    req_yreq[id]           = 1'b1;
    expect_grant(id);
  endtask

  task automatic grant_check(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (YREQ !== 1'b1 && n < 40);
    chk({tag, "_latency"}, n, 1);
    if (YREQ !== 1'b1) return;
    chk({tag, "_sb_empty"}, sb.size() == 0, 0);
    if (sb.size() == 0) return;
    e        = sb.pop_front();
    cur_gid  = e.gid;
    cur_data = e.data;
    chk({tag, "_grant_id"}, GRANT_ID, e.gid);
    chk({tag, "_ydata"},    YDATA,    e.data);
    chk({tag, "_yparity"},  YPARITY,  e.par);
    chk({tag, "_perr"},     PERR,     e.perr);
    chk({tag, "_busy"},     BUSY,     1);
  endtask

  task automatic finish_xfer(input int ack_delay, input int hold);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      chk("fwd_yreq",  YREQ,  1);
      chk("fwd_ydata", YDATA, cur_data);
      if (i == 0) chk("perr_one_cycle", PERR, 0);
    end
    YACK = 1'b1;
    @(negedge clk);
    chk("rels_yreq",     YREQ,     0);
    chk("rels_req_yack", req_yack, 4'b0001 << cur_gid);
    req_yreq[cur_gid] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_req_yack", req_yack, 4'b0001 << cur_gid);
    end
    YACK = 1'b0;
    @(negedge clk);
    chk("idle_req_yack", req_yack, 0);
    chk("idle_busy",     BUSY,     0);
  endtask

  initial begin
    logic [31:0] d;
    rst         = 1'b0;
    req_yreq    = '0;
    req_ydata   = '0;
    req_yparity = '0;
    PARITYSEL   = 1'b0;
    YACK        = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b1;
    @(negedge clk);

    // All four requesting: strict rotation starting at 0, one idle cycle between grants.
    for (int i = 0; i < N; i++) begin
      d = 32'hA500_0000 + 32'(i);
      drive_req(i, d, ^d);
    end
    for (int k = 0; k < 8; k++) begin
      grant_check($sformatf("rr%0d", k));
      finish_xfer(1, 0);
      if (k < 4) begin
        req_yreq[cur_gid] = 1'b1;
        expect_grant(int'(cur_gid));
      end
    end

    // Single requester, sink acks after 2 cycles, parity correct.
    drive_req(0, 32'hDEADBEEF, 1'b0);
    grant_check("single");
    finish_xfer(2, 0);

    // YACK while idle is ignored.
    YACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_yack_busy", BUSY,     0);
      chk("idle_yack_yreq", YREQ,     0);
      chk("idle_yack_ack",  req_yack, 0);
    end
    YACK = 1'b0;
    @(negedge clk);

    // Odd parity selected, wrong parity bit: PERR pulses, transfer completes.
    PARITYSEL = 1'b1;
    drive_req(2, 32'h0000_0001, 1'b1);
    grant_check("perr");
    PARITYSEL = 1'b0;
    finish_xfer(1, 0);

    // Data changed during FWD must not reach YDATA until the next grant.
    d = 32'hCAFEF00D;
    drive_req(1, d, ^d);
    grant_check("latch");
    req_ydata[1*DW +: DW] = 32'h12345678;
    finish_xfer(3, 0);
    d = 32'h12345678;
    drive_req(1, d, ^d);
    grant_check("relatch");
    finish_xfer(1, 0);

    // Sink keeps YACK high 5 cycles after the requester releases.
    d = 32'h0F0F0F0F;
    drive_req(2, d, ^d);
    grant_check("yack_hold");
    finish_xfer(1, 5);

    // Reset mid-FWD: outputs clear immediately, pointer restarts at 0.
    d = 32'h3333_3333;
    drive_req(3, d, ^d);
    grant_check("pre_rst");
    rst = 1'b0;
    #1;
    check_reset_outs("async_rst");
    repeat (2) @(negedge clk);
    d = 32'h0000_00F0;
    drive_req(0, d, ^d);
    expect_grant(3);
    rst = 1'b1;
    grant_check("post_rst0");
    finish_xfer(1, 0);
    grant_check("post_rst3");
    finish_xfer(1, 0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
